prf_read_arbiter: RTL and testbench

Shares the banked physical register file's read ports among all PRF read requestors (issue queues, store/branch operand reads). Each cycle, per bank, picks up to PRF_READ_PORT_COUNT requests using a rotating round-robin priority. Drives the bank read ports from registers and routes the returned bank data back to the winning requestors one cycle after grant.

---
 rtl/core_types_pkg.sv | 27 ++
 rtl/prf_rd_bank_arb.sv | 60 ++++++
 rtl/prf_read_arbiter.sv | 137 +++++++++++++
 tb/tb_prf_read_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared PRF geometry constants and typedefs for the register-file read path.
// Used by prf_read_arbiter (optional PRF_READ_ARB_PERF_EN) and prf_rd_bank_arb.
`default_nettype none

package core_types_pkg;
  localparam int PRF_RR_COUNT         = 11;
  localparam int PRF_BANK_COUNT       = 4;
  localparam int LOG_PRF_BANK_COUNT   = 2;
  localparam int PRF_READ_PORT_COUNT  = 2;
  localparam int PR_COUNT             = 128;
  localparam int LOG_PR_COUNT         = 7;
  localparam int XLEN                 = 32;
  localparam int LOG_PRF_RR_COUNT     = $clog2(PRF_RR_COUNT);
  localparam int PRF_BANK_IDX_W       = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
  localparam int PRF_BANK_PORT_COUNT  = PRF_BANK_COUNT * PRF_READ_PORT_COUNT;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] prf_bank_t;
  typedef logic [LOG_PRF_RR_COUNT-1:0]   prf_rr_idx_t;
  typedef logic [PRF_BANK_IDX_W-1:0]     prf_bank_idx_t;

  function automatic prf_rr_idx_t rr_wrap_inc(input prf_rr_idx_t i);
    return (i == prf_rr_idx_t'(PRF_RR_COUNT - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

`default_nettype wire

// File: rtl/prf_rd_bank_arb.sv
// Per-bank 2-of-N rotating round-robin picker; owns the bank's priority pointer.
// Grant outputs are one-hot over requestors, combinational from cand and the pointer.
`default_nettype none

module prf_rd_bank_arb
  import core_types_pkg::*;
(
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [PRF_RR_COUNT-1:0] cand,
  output logic [PRF_RR_COUNT-1:0] gnt0,
  output logic [PRF_RR_COUNT-1:0] gnt1,
  output logic                    gnt0_valid,
  output logic                    gnt1_valid
);
  localparam int SW = LOG_PRF_RR_COUNT + 1;
  typedef logic [SW-1:0] sum_t;

  prf_rr_idx_t ptr;
  prf_rr_idx_t last;
  prf_rr_idx_t idx;
  sum_t        sum;

  // Walk requestors cyclically from ptr; first hit takes port 0, second port 1.
  always_comb begin
    gnt0       = '0;
    gnt1       = '0;
    gnt0_valid = 1'b0;
    gnt1_valid = 1'b0;
    last       = ptr;
    idx        = '0;
    sum        = '0;
    for (int k = 0; k < PRF_RR_COUNT; k++) begin
      sum = {1'b0, ptr} + sum_t'(k);
      if (sum >= sum_t'(PRF_RR_COUNT)) sum = sum - sum_t'(PRF_RR_COUNT);
      idx = sum[LOG_PRF_RR_COUNT-1:0];
      if (cand[idx]) begin
        if (!gnt0_valid) begin
          gnt0_valid = 1'b1;
          gnt0[idx]  = 1'b1;
          last       = idx;
        end else if (!gnt1_valid) begin
          gnt1_valid = 1'b1;
          gnt1[idx]  = 1'b1;
          last       = idx;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr <= '0;
    end else if (gnt0_valid) begin
      ptr <= rr_wrap_inc(last);
    end
  end
endmodule

`default_nettype wire

// File: rtl/prf_read_arbiter.sv
// Shares banked PRF read ports among requestors; data returns one cycle after ack.
// Optional PRF_READ_ARB_PERF_EN adds a saturating count of un-acked request-cycles.
`default_nettype none

module prf_read_arbiter
  import core_types_pkg::*;
(
  input  logic                                          CLK,
  input  logic                                          nRST,
  input  logic [PRF_RR_COUNT-1:0]                       req_valid,
  input  logic [PRF_RR_COUNT*LOG_PR_COUNT-1:0]          req_pr,
  output logic [PRF_RR_COUNT-1:0]                       req_ack,
  output logic [PRF_BANK_PORT_COUNT-1:0]                bank_rd_valid,
  output logic [PRF_BANK_PORT_COUNT*PRF_BANK_IDX_W-1:0] bank_rd_index,
  input  logic [PRF_BANK_PORT_COUNT*XLEN-1:0]           bank_rd_data,
  output logic [PRF_RR_COUNT-1:0]                       resp_valid,
  output logic [PRF_RR_COUNT*XLEN-1:0]                  resp_data
`ifdef PRF_READ_ARB_PERF_EN
  ,
  output logic [31:0]                                   perf_conflict_count
`endif
);
  pr_t                     pr        [PRF_RR_COUNT];
  logic [PRF_RR_COUNT-1:0] cand      [PRF_BANK_COUNT];
  logic [PRF_RR_COUNT-1:0] gnt       [PRF_BANK_COUNT][PRF_READ_PORT_COUNT];
  logic                    gv        [PRF_BANK_COUNT][PRF_READ_PORT_COUNT];
  prf_bank_idx_t           nxt_idx   [PRF_BANK_PORT_COUNT];
  logic [PRF_RR_COUNT-1:0] port1_hit;
  prf_bank_t               sel_bank  [PRF_RR_COUNT];
  logic                    sel_port  [PRF_RR_COUNT];
  logic [XLEN-1:0]         rd_data   [PRF_BANK_PORT_COUNT];

  always_comb begin
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      pr[i] = req_pr[i*LOG_PR_COUNT +: LOG_PR_COUNT];
    end
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        cand[b][i] = req_valid[i] && (pr[i][LOG_PRF_BANK_COUNT-1:0] == prf_bank_t'(b));
      end
    end
  end

  generate
    for (genvar b = 0; b < PRF_BANK_COUNT; b++) begin : g_bank
      prf_rd_bank_arb u_arb (
        .CLK        (CLK),
        .nRST       (nRST),
        .cand       (cand[b]),
        .gnt0       (gnt[b][0]),
        .gnt1       (gnt[b][1]),
        .gnt0_valid (gv[b][0]),
        .gnt1_valid (gv[b][1])
      );
    end
  endgenerate

  // Each requestor lives in exactly one bank, so OR-ing grants never collides.
  always_comb begin
    req_ack   = '0;
    port1_hit = '0;
    for (int b = 0; b < PRF_BANK_COUNT; b++) begin
      port1_hit = port1_hit | gnt[b][1];
      for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
        req_ack = req_ack | gnt[b][p];
        nxt_idx[b*PRF_READ_PORT_COUNT+p] = '0;
        for (int i = 0; i < PRF_RR_COUNT; i++) begin
          if (gnt[b][p][i]) begin
            nxt_idx[b*PRF_READ_PORT_COUNT+p] = nxt_idx[b*PRF_READ_PORT_COUNT+p]
                                             | pr[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_rd_valid <= '0;
      bank_rd_index <= '0;
      resp_valid    <= '0;
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        sel_bank[i] <= '0;
        sel_port[i] <= 1'b0;
      end
    end else begin
      for (int b = 0; b < PRF_BANK_COUNT; b++) begin
        for (int p = 0; p < PRF_READ_PORT_COUNT; p++) begin
          bank_rd_valid[b*PRF_READ_PORT_COUNT+p] <= gv[b][p];
          bank_rd_index[(b*PRF_READ_PORT_COUNT+p)*PRF_BANK_IDX_W +: PRF_BANK_IDX_W]
            <= nxt_idx[b*PRF_READ_PORT_COUNT+p];
        end
      end
      resp_valid <= req_ack;
      for (int i = 0; i < PRF_RR_COUNT; i++) begin
        if (req_ack[i]) begin
          sel_bank[i] <= pr[i][LOG_PRF_BANK_COUNT-1:0];
          sel_port[i] <= port1_hit[i];
        end
      end
    end
  end

  // Slot index {bank, port} matches the bank_rd_* packing of b*2+p.
  always_comb begin
    for (int s = 0; s < PRF_BANK_PORT_COUNT; s++) begin
      rd_data[s] = bank_rd_data[s*XLEN +: XLEN];
    end
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      resp_data[i*XLEN +: XLEN] = resp_valid[i] ? rd_data[{sel_bank[i], sel_port[i]}] : '0;
    end
  end

`ifdef PRF_READ_ARB_PERF_EN
  localparam int MW = $clog2(PRF_RR_COUNT + 1);
  logic [MW-1:0] miss_cnt;
  logic [32:0]   perf_sum;

  always_comb begin
    miss_cnt = '0;
    for (int i = 0; i < PRF_RR_COUNT; i++) begin
      miss_cnt = miss_cnt + MW'(req_valid[i] & ~req_ack[i]);
    end
    perf_sum = {1'b0, perf_conflict_count} + 33'(miss_cnt);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_conflict_count <= '0;
    end else begin
      perf_conflict_count <= perf_sum[32] ? 32'hFFFF_FFFF : perf_sum[31:0];
    end
  end
`endif
endmodule

`default_nettype wire

// File: tb/tb_prf_read_arbiter.sv
// Self-checking bench: directed table, hand-written corner sequences, random traffic vs model.
`default_nettype none

module tb_prf_read_arbiter;
  import core_types_pkg::*;

  localparam int RR = PRF_RR_COUNT;
  localparam int NB = PRF_BANK_COUNT;
  localparam int NS = PRF_BANK_PORT_COUNT;
  localparam int IW = PRF_BANK_IDX_W;

  logic                 CLK;
  logic                 nRST;
  logic [RR-1:0]        req_valid;
  logic [RR*7-1:0]      req_pr;
  logic [RR-1:0]        req_ack;
  logic [NS-1:0]        bank_rd_valid;
  logic [NS*IW-1:0]     bank_rd_index;
  logic [NS*XLEN-1:0]   bank_rd_data;
  logic [RR-1:0]        resp_valid;
  logic [RR*XLEN-1:0]   resp_data;
`ifdef PRF_READ_ARB_PERF_EN
  logic [31:0]          perf_conflict_count;
  longint               perf_exp;
`endif

  prf_read_arbiter dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .req_valid     (req_valid),
    .req_pr        (req_pr),
    .req_ack       (req_ack),
    .bank_rd_valid (bank_rd_valid),
    .bank_rd_index (bank_rd_index),
    .bank_rd_data  (bank_rd_data),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data)
`ifdef PRF_READ_ARB_PERF_EN
    ,
    .perf_conflict_count (perf_conflict_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total;
  int bad;

  // Reference model state: per-bank pointer and last cycle's grants.
  int            mptr [NB];
  bit            pv   [NB][2];
  int            pgr  [NB][2];
  int            pidx [NB][2];
  bit            cv   [NB][2];
  int            cgr  [NB][2];
  logic [RR-1:0] exp_ack;

  typedef struct {
    logic [RR-1:0]   vld;
    logic [RR*7-1:0] pr;
    logic [RR-1:0]   ack;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int pr_of(input int i);
    return int'(req_pr[i*7 +: 7]);
  endfunction

  function automatic logic [RR*7-1:0] setpr(input logic [RR*7-1:0] f, input int i, input int v);
    f[i*7 +: 7] = 7'(v);
    return f;
  endfunction

  task automatic model_eval();
    exp_ack = '0;
    for (int b = 0; b < NB; b++) begin
      int n;
      n = 0;
      cv[b][0] = 0; cv[b][1] = 0; cgr[b][0] = 0; cgr[b][1] = 0;
      for (int k = 0; k < RR; k++) begin
        int i;
        i = (mptr[b] + k) % RR;
        if (req_valid[i] && (pr_of(i) % NB) == b && n < 2) begin
          cv[b][n]   = 1;
          cgr[b][n]  = i;
          exp_ack[i] = 1'b1;
          n++;
        end
      end
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      mptr[b] = 0;
      for (int p = 0; p < 2; p++) begin
        pv[b][p] = 0; pgr[b][p] = 0; pidx[b][p] = 0;
      end
    end
`ifdef PRF_READ_ARB_PERF_EN
    perf_exp = 0;
`endif
  endtask

  task automatic model_compare();
    logic [NS-1:0]      ev;
    logic [NS*IW-1:0]   ei;
    logic [RR-1:0]      erv;
    logic [RR*XLEN-1:0] erd;
    model_eval();
    ev = '0; ei = '0; erv = '0; erd = '0;
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < 2; p++) begin
        ev[b*2+p]          = pv[b][p];
        ei[(b*2+p)*IW +: IW] = IW'(pidx[b][p]);
        if (pv[b][p]) begin
          erv[pgr[b][p]] = 1'b1;
          erd[pgr[b][p]*XLEN +: XLEN] = bank_rd_data[(b*2+p)*XLEN +: XLEN];
        end
      end
    end
    check("m_ack", 512'(req_ack), 512'(exp_ack));
    check("m_bank_rd_valid", 512'(bank_rd_valid), 512'(ev));
    check("m_bank_rd_index", 512'(bank_rd_index), 512'(ei));
    check("m_resp_valid", 512'(resp_valid), 512'(erv));
    check("m_resp_data", 512'(resp_data), 512'(erd));
`ifdef PRF_READ_ARB_PERF_EN
    check("m_perf", 512'(perf_conflict_count), 512'(perf_exp));
`endif
  endtask

  task automatic model_update();
    model_eval();
`ifdef PRF_READ_ARB_PERF_EN
    perf_exp = perf_exp + $countones(req_valid & ~exp_ack);
    if (perf_exp > 64'hFFFF_FFFF) perf_exp = 64'hFFFF_FFFF;
`endif
    for (int b = 0; b < NB; b++) begin
      for (int p = 0; p < 2; p++) begin
        pv[b][p]   = cv[b][p];
        pgr[b][p]  = cgr[b][p];
        pidx[b][p] = cv[b][p] ? pr_of(cgr[b][p]) / NB : 0;
      end
      if (cv[b][0]) mptr[b] = ((cv[b][1] ? cgr[b][1] : cgr[b][0]) + 1) % RR;
    end
  endtask

  task automatic adv();
    @(posedge CLK);
    model_update();
    #1;
    for (int s = 0; s < NS; s++) bank_rd_data[s*XLEN +: XLEN] = $urandom;
  endtask

  task automatic cyc();
    @(negedge CLK);
    model_compare();
  endtask

  task automatic do_reset();
    req_valid = '0;
    nRST = 1'b0;
    #2;
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    adv();
  endtask

  task automatic all_bank2();
    req_valid = '1;
    for (int i = 0; i < RR; i++) req_pr = setpr(req_pr, i, i*4 + 2);
  endtask

  logic [RR-1:0] rot_exp [6];
  logic [XLEN-1:0] word;

  initial begin
    total = 0;
    bad   = 0;
    nRST  = 1'b0;
    req_valid = RR'($urandom);
    req_pr    = '0;
    for (int i = 0; i < RR; i++) req_pr[i*7 +: 7] = 7'($urandom);
    for (int s = 0; s < NS; s++) bank_rd_data[s*XLEN +: XLEN] = $urandom;

    // Reset held with random requests: outputs zero, ack arbitrates from pointer 0.
    #2;
    model_reset();
    model_compare();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    model_compare();
    adv();

    tbl[0].vld = 11'h111; tbl[0].pr = '0;
    tbl[0].pr = setpr(tbl[0].pr, 4, 4); tbl[0].pr = setpr(tbl[0].pr, 8, 8);
    tbl[0].ack = 11'h011;
    tbl[1].vld = 11'h00F; tbl[1].pr = '0;
    tbl[1].pr = setpr(tbl[1].pr, 0, 1); tbl[1].pr = setpr(tbl[1].pr, 1, 2);
    tbl[1].pr = setpr(tbl[1].pr, 2, 3); tbl[1].pr = setpr(tbl[1].pr, 3, 0);
    tbl[1].ack = 11'h00F;
    tbl[2].vld = 11'h7FF; tbl[2].pr = '0;
    for (int i = 0; i < RR; i++) tbl[2].pr = setpr(tbl[2].pr, i, i*4 + 2);
    tbl[2].ack = 11'h003;
    tbl[3].vld = 11'h000; tbl[3].pr = '0; tbl[3].ack = 11'h000;
    tbl[4].vld = 11'h0E0; tbl[4].pr = '0;
    tbl[4].pr = setpr(tbl[4].pr, 5, 5); tbl[4].pr = setpr(tbl[4].pr, 6, 9);
    tbl[4].pr = setpr(tbl[4].pr, 7, 13);
    tbl[4].ack = 11'h060;
    tbl[5].vld = 11'h600; tbl[5].pr = '0;
    tbl[5].pr = setpr(tbl[5].pr, 9, 9); tbl[5].pr = setpr(tbl[5].pr, 10, 10);
    tbl[5].ack = 11'h600;

    for (int e = 0; e < 6; e++) begin
      do_reset();
      req_valid = tbl[e].vld;
      req_pr    = tbl[e].pr;
      cyc();
      check($sformatf("tbl%0d_ack", e), 512'(req_ack), 512'(tbl[e].ack));
      adv();
      req_valid = '0;
      cyc();
      check($sformatf("tbl%0d_resp_valid", e), 512'(resp_valid), 512'(tbl[e].ack));
      adv();
    end

    // Three requestors in bank 0: third waits one cycle.
    do_reset();
    req_valid = tbl[0].vld;
    req_pr    = tbl[0].pr;
    cyc();
    check("b0_ack_t", 512'(req_ack), 512'(11'h011));
    adv();
    req_valid = 11'h100;
    cyc();
    check("b0_ack_t1", 512'(req_ack), 512'(11'h100));
    check("b0_rd_valid", 512'(bank_rd_valid), 512'(8'h03));
    check("b0_rd_index", 512'(bank_rd_index[9:0]), 512'({5'd1, 5'd0}));
    check("b0_resp_valid", 512'(resp_valid), 512'(11'h011));
    adv();
    req_valid = '0;
    cyc();
    check("b0_resp_valid2", 512'(resp_valid), 512'(11'h100));
    adv();

    // All requestors in one bank held: pairs rotate and wrap.
    rot_exp[0] = 11'h003; rot_exp[1] = 11'h00C; rot_exp[2] = 11'h030;
    rot_exp[3] = 11'h0C0; rot_exp[4] = 11'h300; rot_exp[5] = 11'h401;
    do_reset();
    all_bank2();
    for (int c = 0; c < 6; c++) begin
      cyc();
      check($sformatf("rot%0d_ack", c), 512'(req_ack), 512'(rot_exp[c]));
      adv();
    end

    // Requestor 7 on bank 1 port 1 receives that port's data.
    do_reset();
    req_valid = 11'h0C0;
    req_pr = '0;
    req_pr = setpr(req_pr, 6, 1);
    req_pr = setpr(req_pr, 7, 5);
    cyc();
    check("p11_ack", 512'(req_ack), 512'(11'h0C0));
    adv();
    req_valid = '0;
    bank_rd_data[3*XLEN +: XLEN] = 32'hDEADBEEF;
    cyc();
    word = resp_data[7*XLEN +: XLEN];
    check("p11_data", 512'(word), 512'(32'hDEADBEEF));
    check("p11_valid", 512'(resp_valid[7]), 512'(1'b1));
    adv();

    // Asynchronous reset while responses are in flight.
    do_reset();
    all_bank2();
    cyc();
    adv();
    check("rst_pre_rv", 512'(resp_valid), 512'(11'h003));
    nRST = 1'b0;
    #1;
    model_reset();
    check("rst_rv", 512'(resp_valid), 512'(0));
    check("rst_bv", 512'(bank_rd_valid), 512'(0));
    model_compare();
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    model_compare();
    check("rst_ack0", 512'(req_ack), 512'(11'h003));
    adv();
    cyc();
    check("rst_ack1", 512'(req_ack), 512'(11'h00C));
    adv();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 500; n++) begin
      req_valid = RR'($urandom);
      for (int i = 0; i < RR; i++) req_pr[i*7 +: 7] = 7'($urandom);
      cyc();
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
